// File: rtl/multi_delay_timer.sv
// ---------------------------------------------------------------------------
// multi_delay_timer
//
// NUM_CH independent programmable delay / pulse timers. Each channel has its
// own asynchronous trigger, which is synchronised and edge-detected. Every
// accepted trigger edge latches that channel's mode, delay and pulse settings.
// The channel then drives an active-low registered output, either at once or
// after a counted number of cycles.
//
// Modes (per channel):
//   00 one-shot         rise -> low now, high again after pulse_val cycles
//   01 delayed operate  rise -> low after delay_val; fall -> high (abort)
//   10 delayed release  rise -> low now; fall -> high after delay_val
//   11 dual delay       both edges take effect after delay_val
//
// Build option:
//   MULTI_DELAY_TIMER_RETRIG_EN - when defined, a rise during a mode-00
//   pulse restarts the pulse with a freshly latched pulse_val. When it is
//   undefined, that rise is ignored and nothing is re-latched.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   trigger_in   [NUM_CH]            asynchronous trigger per channel
//   ch_enable    [NUM_CH]            synchronous level enable per channel
//   mode         [2*NUM_CH]          2-bit mode per channel
//   delay_val    [NUM_CH*CNT_WIDTH]  delay in cycles per channel
//   pulse_val    [NUM_CH*CNT_WIDTH]  one-shot width in cycles per channel
//   delay_out_n  [NUM_CH]            registered active-low output
//   busy         [NUM_CH]            registered, 1 while counting
//
// Channel FSM:
//   state | meaning
//   IDLE  | not counting, output holds its value
//   COUNT | counter runs 0..target; the pending level is applied at target
// ---------------------------------------------------------------------------
module multi_delay_timer #(
    parameter int NUM_CH    = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH-1:0]             trigger_in,
    input  logic [NUM_CH-1:0]             ch_enable,
    input  logic [2*NUM_CH-1:0]           mode,
    input  logic [NUM_CH*CNT_WIDTH-1:0]   delay_val,
    input  logic [NUM_CH*CNT_WIDTH-1:0]   pulse_val,
    output logic [NUM_CH-1:0]             delay_out_n,
    output logic [NUM_CH-1:0]             busy
);

`ifdef MULTI_DELAY_TIMER_RETRIG_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } ch_state_t;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [2:0]           sync_q;
        logic                 rise;
        logic                 fall;
        ch_state_t            state_q;
        ch_state_t            state_d;
        logic [CNT_WIDTH-1:0] cnt_q;
        logic [CNT_WIDTH-1:0] cnt_d;
        logic                 out_q;
        logic                 out_d;
        logic                 pend_q;
        logic                 pend_d;
        logic                 busy_q;
        logic [1:0]           mode_q;
        logic [CNT_WIDTH-1:0] delay_q;
        logic [CNT_WIDTH-1:0] pulse_q;
        logic                 latch_cfg;
        logic                 handled;
        logic [1:0]           new_mode;
        logic [CNT_WIDTH-1:0] tgt_val;
        logic [CNT_WIDTH-1:0] tgt;

        // sync_q[0..1] form the synchroniser, sync_q[2] is the edge-detect delay.
        assign rise     = sync_q[1] & ~sync_q[2];
        assign fall     = ~sync_q[1] & sync_q[2];
        assign new_mode = mode[2*i +: 2];

        // Only mode 00 counts pulse width; a programmed 0 behaves as 1.
        assign tgt_val = (mode_q == 2'b00) ? pulse_q : delay_q;
        assign tgt     = (tgt_val == '0) ? '0 : tgt_val - CNT_WIDTH'(1);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[1:0], trigger_in[i]};
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                out_q   <= 1'b1;
                pend_q  <= 1'b1;
                busy_q  <= 1'b0;
                mode_q  <= '0;
                delay_q <= '0;
                pulse_q <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                out_q   <= out_d;
                pend_q  <= pend_d;
                busy_q  <= (state_d == COUNT);
                if (latch_cfg) begin
                    mode_q  <= new_mode;
                    delay_q <= delay_val[i*CNT_WIDTH +: CNT_WIDTH];
                    pulse_q <= pulse_val[i*CNT_WIDTH +: CNT_WIDTH];
                end
            end
        end

        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            out_d     = out_q;
            pend_d    = pend_q;
            latch_cfg = 1'b0;
            handled   = 1'b0;

            if (!ch_enable[i]) begin
                state_d = IDLE;
                cnt_d   = '0;
                out_d   = 1'b1;
            end else begin
                // The mode being latched by this event decides how it is handled.
                if (rise || fall) begin
                    case (new_mode)
                        2'b00: begin
                            if (rise) begin
                                if (state_q == IDLE || RETRIG) begin
                                    latch_cfg = 1'b1;
                                    handled   = 1'b1;
                                    out_d     = 1'b0;
                                    state_d   = COUNT;
                                    cnt_d     = '0;
                                    pend_d    = 1'b1;
                                end
                            end else begin
                                // A fall has no action in one-shot mode; the
                                // running pulse (if any) carries on.
                                latch_cfg = 1'b1;
                            end
                        end
                        2'b01: begin
                            latch_cfg = 1'b1;
                            handled   = 1'b1;
                            cnt_d     = '0;
                            if (rise) begin
                                state_d = COUNT;
                                pend_d  = 1'b0;
                            end else begin
                                state_d = IDLE;
                                out_d   = 1'b1;
                            end
                        end
                        2'b10: begin
                            latch_cfg = 1'b1;
                            handled   = 1'b1;
                            cnt_d     = '0;
                            if (rise) begin
                                state_d = IDLE;
                                out_d   = 1'b0;
                            end else begin
                                state_d = COUNT;
                                pend_d  = 1'b1;
                            end
                        end
                        2'b11: begin
                            latch_cfg = 1'b1;
                            handled   = 1'b1;
                            cnt_d     = '0;
                            state_d   = COUNT;
                            pend_d    = fall;
                        end
                    endcase
                end

                if (!handled && state_q == COUNT) begin
                    if (cnt_q == tgt) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        out_d   = pend_q;
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
        end

        assign delay_out_n[i] = out_q;
        assign busy[i]        = busy_q;
    end

endmodule

// File: tb/tb_multi_delay_timer.sv
module tb_multi_delay_timer;
    localparam int NC = 4;
    localparam int W  = 16;

`ifdef MULTI_DELAY_TIMER_RETRIG_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NC-1:0]     trigger_in = '0;
    logic [NC-1:0]     ch_enable = '0;
    logic [2*NC-1:0]   mode = '0;
    logic [NC*W-1:0]   delay_val = '0;
    logic [NC*W-1:0]   pulse_val = '0;
    logic [NC-1:0]     delay_out_n;
    logic [NC-1:0]     busy;

    multi_delay_timer #(.NUM_CH(NC), .CNT_WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .trigger_in(trigger_in),
        .ch_enable(ch_enable),
        .mode(mode),
        .delay_val(delay_val),
        .pulse_val(pulse_val),
        .delay_out_n(delay_out_n),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int low_cnt0 = 0;

    typedef struct {
        int            cyc;
        logic [NC-1:0] out;
        logic [NC-1:0] bsy;
    } exp_t;
    exp_t sbq[$];

    // Reference model: per channel, the output level, whether a timed action
    // is outstanding, the absolute cycle in which it becomes visible and the
    // level it will apply.
    bit            m_out[NC];
    bit            m_cnt[NC];
    bit            m_pend[NC];
    int            m_dl[NC];
    int            c_mode[NC];
    int            c_delay[NC];
    int            c_pulse[NC];
    logic [NC-1:0] h1, h2, h3;
    logic [NC-1:0] cur_trig = '0;
    logic [NC-1:0] cur_en = '0;

    task automatic apply_inputs();
        trigger_in = cur_trig;
        ch_enable  = cur_en;
        for (int c = 0; c < NC; c++) begin
            mode[2*c +: 2]      = c_mode[c][1:0];
            delay_val[c*W +: W] = c_delay[c][W-1:0];
            pulse_val[c*W +: W] = c_pulse[c][W-1:0];
        end
    endtask

    function automatic void model_reset();
        h1 = '0; h2 = '0; h3 = '0;
        for (int c = 0; c < NC; c++) begin
            m_out[c] = 1'b1;
            m_cnt[c] = 1'b0;
            m_pend[c] = 1'b1;
            m_dl[c] = 0;
        end
    endfunction

    function automatic void start_timer(int c, int v, bit p, int k);
        m_cnt[c]  = 1'b1;
        m_dl[c]   = k + 1 + ((v == 0) ? 1 : v);
        m_pend[c] = p;
    endfunction

    // Inputs of cycle k are in place; compute what the outputs show in k+1.
    function automatic void model_eval();
        int   k;
        exp_t e;
        k = cyc;
        for (int c = 0; c < NC; c++) begin
            bit r, f, ign;
            r   = h2[c] & ~h3[c];
            f   = ~h2[c] & h3[c];
            ign = 1'b1;
            if (!cur_en[c]) begin
                m_cnt[c] = 1'b0;
                m_out[c] = 1'b1;
            end else begin
                if (r || f) begin
                    case (c_mode[c])
                        0: if (r && (!m_cnt[c] || RETRIG)) begin
                               ign = 1'b0;
                               m_out[c] = 1'b0;
                               start_timer(c, c_pulse[c], 1'b1, k);
                           end
                        1: begin
                               ign = 1'b0;
                               if (r) start_timer(c, c_delay[c], 1'b0, k);
                               else begin m_cnt[c] = 1'b0; m_out[c] = 1'b1; end
                           end
                        2: begin
                               ign = 1'b0;
                               if (r) begin m_cnt[c] = 1'b0; m_out[c] = 1'b0; end
                               else start_timer(c, c_delay[c], 1'b1, k);
                           end
                        default: begin
                               ign = 1'b0;
                               start_timer(c, c_delay[c], f, k);
                           end
                    endcase
                end
                if (ign && m_cnt[c] && m_dl[c] == k + 1) begin
                    m_out[c] = m_pend[c];
                    m_cnt[c] = 1'b0;
                end
            end
        end
        h3 = h2; h2 = h1; h1 = cur_trig;
        e.cyc = k + 1;
        for (int c = 0; c < NC; c++) begin
            e.out[c] = m_out[c];
            e.bsy[c] = m_cnt[c];
        end
        sbq.push_back(e);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        apply_inputs();
        model_eval();
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cur_trig = '0;
        cur_en = '0;
        apply_inputs();
        sbq.delete();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (delay_out_n !== '1 || busy !== '0) begin
            failures++;
            $display("FAIL reset_hold got out=%b busy=%b exp out=1111 busy=0000", delay_out_n, busy);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        apply_inputs();
        model_eval();
    endtask

    // Monitor: compares DUT outputs against the scoreboard every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (delay_out_n[0] === 1'b0) low_cnt0++;
                while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                    e = sbq.pop_front();
                    checks++;
                    failures++;
                    $display("FAIL stale_entry cyc=%0d entry_cyc=%0d", cyc, e.cyc);
                end
                if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
                    e = sbq.pop_front();
                    checks += 2;
                    if (delay_out_n !== e.out) begin
                        failures++;
                        $display("FAIL delay_out_n cyc=%0d got=%b exp=%b", cyc, delay_out_n, e.out);
                    end
                    if (busy !== e.bsy) begin
                        failures++;
                        $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, e.bsy);
                    end
                end
            end
        end
    end

    initial begin
        for (int c = 0; c < NC; c++) begin
            c_mode[c] = 0; c_delay[c] = 0; c_pulse[c] = 0;
        end
        model_reset();
        do_reset();

        // One-shot, pulse 5, fall two cycles after the rise event.
        cur_en = '1;
        c_mode[0] = 0; c_pulse[0] = 5;
        c_mode[1] = 1; c_delay[1] = 10;
        c_mode[2] = 2; c_delay[2] = 8;
        c_mode[3] = 3; c_delay[3] = 4;
        run(5);
        low_cnt0 = 0;
        cur_trig[0] = 1'b1; run(2);
        cur_trig[0] = 1'b0; run(15);
        checks++;
        if (low_cnt0 != 5) begin
            failures++;
            $display("FAIL oneshot_low_len got=%0d exp=5", low_cnt0);
        end

        // Delayed operate: long hold, then a hold shorter than the delay.
        cur_trig[1] = 1'b1; run(20);
        cur_trig[1] = 1'b0; run(5);
        cur_trig[1] = 1'b1; run(6);
        cur_trig[1] = 1'b0; run(15);

        // Delayed release with a second rise four cycles after the fall.
        cur_trig[2] = 1'b1; run(5);
        cur_trig[2] = 1'b0; run(4);
        cur_trig[2] = 1'b1; run(6);
        cur_trig[2] = 1'b0; run(15);

        // Dual delay, quick re-rise, then disable mid-count.
        cur_trig[3] = 1'b1; run(10);
        cur_trig[3] = 1'b0; run(2);
        cur_trig[3] = 1'b1; run(8);
        cur_trig[3] = 1'b0; run(2);
        cur_en[3] = 1'b0; run(3);
        cur_en[3] = 1'b1; run(10);

        // One-shot retrigger three cycles into the pulse.
        c_pulse[0] = 6;
        run(3);
        low_cnt0 = 0;
        cur_trig[0] = 1'b1; run(1);
        cur_trig[0] = 1'b0; run(2);
        cur_trig[0] = 1'b1; run(1);
        cur_trig[0] = 1'b0; run(20);
        checks++;
        if (low_cnt0 != (RETRIG ? 9 : 6)) begin
            failures++;
            $display("FAIL retrig_low_len got=%0d exp=%0d", low_cnt0, RETRIG ? 9 : 6);
        end

        // Asynchronous reset in the middle of a pulse.
        c_pulse[0] = 10;
        run(2);
        cur_trig[0] = 1'b1; run(6);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (delay_out_n !== '1 || busy !== '0) begin
            failures++;
            $display("FAIL reset_midcount got out=%b busy=%b exp out=1111 busy=0000", delay_out_n, busy);
        end
        do_reset();

        // Randomised phases: fixed config per phase, random edges and enables.
        for (int p = 0; p < 30; p++) begin
            for (int c = 0; c < NC; c++) begin
                c_mode[c]  = $urandom_range(0, 3);
                c_delay[c] = $urandom_range(0, 12);
                c_pulse[c] = $urandom_range(0, 12);
            end
            for (int t = 0; t < 120; t++) begin
                for (int c = 0; c < NC; c++) begin
                    if ($urandom_range(0, 4) == 0) cur_trig[c] = ~cur_trig[c];
                    cur_en[c] = ($urandom_range(0, 29) != 0);
                end
                step();
            end
            cur_en = '1;
            run(20);
        end

        run(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_delay_timer.md
Name: multi_delay_timer

Overview:
Multi-channel programmable delay timer. NUM_CH independent channels, each with its own trigger input, mode, delay/pulse values and active-low output.
Fully synchronous to clk, with explicit per-channel state machines and no combinational latches.
Sits between external trigger sources (asynchronous) and downstream active-low enable/gating logic.

Parameters:
NUM_CH, 4, number of independent timer channels (>=1)
CNT_WIDTH, 16, width of each channel's counter and of delay_val/pulse_val fields (>=2)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
trigger_in  input  NUM_CH  per-channel asynchronous trigger, bit i = channel i
ch_enable  input  NUM_CH  per-channel enable, synchronous, level
mode  input  2*NUM_CH  per-channel mode, bits [2i+1:2i] = channel i
delay_val  input  NUM_CH*CNT_WIDTH  per-channel delay in cycles, field i = bits [(i+1)*CNT_WIDTH-1 : i*CNT_WIDTH]
pulse_val  input  NUM_CH*CNT_WIDTH  per-channel one-shot pulse width in cycles, same field layout
delay_out_n  output  NUM_CH  per-channel active-low output, registered
busy  output  NUM_CH  per-channel flag, 1 while the channel is counting, registered

Behaviour:
- Reset (rst=1, async): delay_out_n = all 1s; busy = 0; all channels in IDLE; counters = 0; sync flops = 0; latched config = 0.
- Trigger path per channel:
  - trigger_in passes through a 2-flop synchroniser, then a third flop for edge detection.
  - rise/fall event pulse is 1 cycle wide.
  - Call the cycle in which the event is valid E. This is 3 clk edges after trigger_in changes when setup is met.
- Config latch: mode, delay_val and pulse_val are captured on every rise or fall event. The channel uses only latched values until the next event.
- Counter value 0 is treated as 1.
- States per channel:
  - IDLE: not counting.
  - COUNT: counter runs from 0 up to latched value-1.
  - A pending action is defined on entry to COUNT.
  - On counter == value-1, the pending action is applied and the channel returns to IDLE.
- Output timing:
  - Immediate actions appear on delay_out_n at E+1.
  - Timed actions appear at E+1+value.
  - busy=1 from E+1 until the cycle the timed action appears. In that cycle busy=0.
- Mode 00, one-shot:
  - Rise: delay_out_n=0 immediately; COUNT(pulse_val); pending action is release to 1.
  - Fall: ignored.
  - Rise while in COUNT: ignored (see RETRIG_EN).
- Mode 01, delayed operate:
  - Rise: COUNT(delay_val); pending action is assert 0.
  - Fall in COUNT: abort to IDLE, output stays 1.
  - Fall in IDLE: delay_out_n=1 at E+1.
- Mode 10, delayed release:
  - Rise: delay_out_n=0 immediately. Any running count is cancelled and the channel goes to IDLE.
  - Fall: COUNT(delay_val); pending action is release to 1.
- Mode 11, dual delay:
  - Rise: COUNT(delay_val); pending action is assert 0.
  - Fall: COUNT(delay_val); pending action is release to 1.
  - An edge during COUNT restarts the counter at 0 with the new pending action. The output holds its current value.
- Output state across a mode change: the output state is kept across mode changes. A new mode takes effect from the event that latches it.
- ch_enable=0:
  - Channel is forced to IDLE, delay_out_n=1, busy=0.
  - Events are ignored. Synchronisers keep running, so no stale edge fires on re-enable.
- Simultaneous events: channels are fully independent. Within a channel only one event per cycle is possible.
- Reset mid-count: reset dominates; outputs return to reset values immediately (async).

Optional Feature:
- Macro: MULTI_DELAY_TIMER_RETRIG_EN.
- Defined: in mode 00, a rise during COUNT restarts the counter at 0 using a newly latched pulse_val. The output stays 0, so the pulse is extended.
- Undefined: a rise during a mode-00 COUNT is ignored, and the config is not re-latched for that event.

Test Plan:
- Reset with NUM_CH=4 -> delay_out_n=4'b1111, busy=0; assert rst mid-count -> outputs return to 1 within the same cycle.
- Ch0 mode 00, pulse_val=5, trigger rise at E -> delay_out_n[0]=0 for exactly 5 cycles (E+1..E+5); busy[0]=1 on E+1..E+5, 0 on E+6; a fall at E+2 has no effect.
- Ch1 mode 01, delay_val=10:
  - trigger held 20 cycles -> output 0 at E+11, 1 again one cycle after the fall event.
  - trigger held only 6 cycles -> output never goes low.
- Ch2 mode 10, delay_val=8: rise -> 0 at E+1; fall at event F -> 1 at F+9; second rise at F+4 -> stays 0, busy drops.
- Ch3 mode 11, delay_val=4: rise -> 0 at E+5; fall -> 1 at F+5; rise 2 cycles after a fall -> counter restarts and output stays 0. ch_enable[3]=0 mid-count -> output 1 next cycle.
- With MULTI_DELAY_TIMER_RETRIG_EN, mode 00, pulse_val=6, second rise 3 cycles into the pulse -> total low time 3+6=9 cycles. Without the macro -> 6 cycles.
